// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared registered ALU.
// Each grant latches the winner's operands and pulses alu_en for one cycle.
// The following cycle waits for the ALU, and the cycle after that returns the
// result to the winner with a one-cycle done pulse.
module alu_rr_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] res0,
    output logic [31:0] res1,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_en,
    input  logic [31:0] alu_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;   // requester granted most recently
    logic        r_win;    // requester owning the operation in flight
    logic        r_ack0;
    logic        r_ack1;
    logic        r_done0;
    logic        r_done1;
    logic [31:0] r_res0;
    logic [31:0] r_res1;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [1:0]  r_alu_op;
    logic        r_alu_en;
    logic        r_busy;

    logic        w_any_req;
    logic        w_pick1;

    // Requester 1 wins when it is alone, or on contention when 0 went last.
    assign w_any_req = req0 | req1;
    assign w_pick1   = req1 & (~req0 | ~r_last);

    // Single FSM: grant in IDLE, one issue cycle, one wait cycle, then deliver.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_res0   <= '0;
            r_res1   <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= '0;
            r_alu_en <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    if (w_any_req) begin
                        r_win    <= w_pick1;
                        r_alu_a  <= w_pick1 ? a1  : a0;
                        r_alu_b  <= w_pick1 ? b1  : b0;
                        r_alu_op <= w_pick1 ? op1 : op0;
                        r_alu_en <= 1'b1;
                        r_ack0   <= ~w_pick1;
                        r_ack1   <= w_pick1;
                        r_busy   <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_alu_en <= 1'b0;
                    r_state  <= WAIT;
                end
                WAIT: begin
                    if (r_win) begin
                        r_res1  <= alu_result;
                        r_done1 <= 1'b1;
                    end else begin
                        r_res0  <= alu_result;
                        r_done0 <= 1'b1;
                    end
                    r_last  <= r_win;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_alu_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ack0   = r_ack0;
    assign ack1   = r_ack1;
    assign done0  = r_done0;
    assign done1  = r_done1;
    assign res0   = r_res0;
    assign res1   = r_res1;
    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;
    assign alu_en = r_alu_en;
    assign busy   = r_busy;

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request from requester 0 / 1.
- a0, b0 / a1, b1  in  32  operands of requester 0 / 1.
- op0 / op1  in  2  ALU opcode of requester 0 / 1.
- ack0 / ack1  out  1  one-cycle grant pulse; operands are latched at the same edge.
- done0 / done1  out  1  one-cycle completion pulse.
- res0 / res1  out  32  result of the last completed operation for that requester.
- alu_a, alu_b  out  32  operands driven to the shared ALU.
- alu_op  out  2  opcode driven to the shared ALU.
- alu_en  out  1  ALU enable.
- alu_result  in  32  ALU registered result; updates on the posedge where alu_en=1.
- busy  out  1  high while state is not IDLE.

REQ-002 All outputs SHALL be registered.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE and WAIT, encoded in 2 bits. The unused encoding SHALL go to IDLE.

REQ-004 IDLE:
- req0/req1 are sampled only in IDLE.
- If any req is high at a posedge, the block selects a winner W and, at that edge:
  - latches aW, bW, opW into alu_a, alu_b, alu_op;
  - sets alu_en=1 and ackW=1;
  - moves to ISSUE.

REQ-005 ISSUE (exactly one cycle): at the next posedge the block sets ackW=0 and alu_en=0 and moves to WAIT. The ALU samples alu_en=1 at this edge.

REQ-006 WAIT (exactly one cycle): at the next posedge the block:
- loads resW with alu_result;
- sets doneW=1;
- sets last=W;
- moves to IDLE.

REQ-007 doneW SHALL clear at the following posedge. A new grant MAY be issued at that same edge.

REQ-008 Latency and throughput:
- req sampled at edge k -> ack high after edge k -> done high after edge k+2.
- Earliest next grant is at edge k+3, so one operation completes per 3 cycles.

REQ-009 Arbitration:
- Only one request high: that requester is granted.
- Both high: the requester other than `last` is granted (round-robin).
- `last` resets to 1, so requester 0 wins the first contention.

REQ-010 A requester SHALL hold req and operands stable until its ack. Operand changes after ack SHALL NOT affect the operation in flight.

REQ-011 A req still high in IDLE after its done SHALL be treated as a new request.

REQ-012 resX SHALL hold its value until the next doneX. resX SHALL never change when doneX is not being set.

REQ-013 alu_a, alu_b and alu_op SHALL hold their last values outside ISSUE.

REQ-014 Operands and opcode SHALL pass through unmodified; the block performs no arithmetic.

REQ-015 At most one of ack0/ack1 and at most one of done0/done1 SHALL be high in any cycle.

Reset
REQ-016 While reset is high, the block SHALL asynchronously force:
- state=IDLE, last=1;
- ack0, ack1, done0, done1, alu_en, busy = 0;
- res0, res1, alu_a, alu_b = 0;
- alu_op = 0.

REQ-017 Reset mid-operation (ISSUE or WAIT) SHALL drop the operation: no done pulse, and resX is zeroed.

REQ-018 After reset deasserts, the first posedge with req high SHALL grant normally.

Verification
The bench pairs the block with the team ALU (op 0 = add, op 1 = sub).

REQ-019 Single request: req0=1, a0=5, b0=3, op0=0.
-> ack0 pulses one cycle; done0 pulses 2 cycles later; res0=8; busy high for 2 cycles.

REQ-020 Simultaneous requests: req0=req1=1 at the same edge after reset.
-> ack0 first, res0 delivered.
-> ack1 at the edge after done0.
-> Re-asserting both again grants 0, then 1 (strict alternation).

REQ-021 Wrap-around: a1=0, b1=1, op1=1.
-> res1=32'hFFFFFFFF.
-> res0 is unchanged and done0 stays 0.

REQ-022 Operand change after grant: a0=10, b0=4, op0=1; a0 set to 99 in the cycle after ack0.
-> res0=6.

REQ-023 Reset during ISSUE:
-> all outputs read 0 immediately, with no clock edge required.
-> No done pulse is seen.
-> After release, req1 with a1=7, b1=2, op1=0 -> res1=9.
